interrupt_controller: RTL and testbench
=======================================

// Module: interrupt_controller
// PURPOSE
//  Parametrised interrupt controller between peripherals and the multicycle
//  processor core. Generalises the core's single INT/NMI request pair to
//  NUM_IRQ maskable channels with fixed priority, per-channel edge/level mode,
//  a vector output and one level of NMI nesting. Drives the core's request
//  lines and consumes its acknowledge (inta) and end-of-interrupt (eoi) strobes.
// PARAMETERS
//  NUM_IRQ   8          number of maskable channels (1..32)
//  EDGE_MODE 8'hFF      per-channel bit: 1 = rising-edge latched, 0 = level
//  VEC_W     8          width of int_vec
//  VEC_BASE  8'h20      vector of channel 0; channel i -> VEC_BASE+i (mod 2^VEC_W)
//  NMI_VEC   8'h02      vector presented for NMI
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst_n      in   1        asynchronous active-low reset
//  irq        in   NUM_IRQ  peripheral requests, synchronous to clk
//  nmi        in   1        non-maskable request, rising-edge sensitive
//  inta       in   1        1-cycle acknowledge strobe from core
//  eoi        in   1        1-cycle end-of-interrupt strobe from core
//  mask_we    in   1        write mask register this cycle
//  mask_wdata in   NUM_IRQ  new mask value (1 = channel masked)
//  mask       out  NUM_IRQ  current mask register
//  pending    out  NUM_IRQ  current pending register
//  int_req    out  1        maskable request to core
//  nmi_req    out  1        NMI request to core
//  int_vec    out  VEC_W    vector of the request being presented/serviced
//  in_service out  1        high in SERVICE or NMI_SVC
// BEHAVIOUR
//  Reset (async, rst_n=0): mask=all 1s, pending=0, irq_d=0, nmi_d=0, nmi_pend=0,
//   saved=0, state=IDLE, int_req=0, nmi_req=0, int_vec=0, in_service=0.
//   Reset mid-request/service drops everything immediately; no ack needed.
//  Pending: edge channel bit sets at edge k when irq=1 & irq_d=0 at k; clears on
//   inta accepting that channel; set beats clear on the same edge. Level channel
//   bit = registered irq, never cleared by inta. nmi_pend sets on nmi rising edge,
//   clears on inta in NMI_REQ; set beats clear.
//  active = pending & ~mask; highest priority = lowest set index.
//  mask_we updates mask at next edge; takes effect on the following cycle.
//  FSM (registered outputs):
//   IDLE:    nmi_pend -> NMI_REQ (int_vec=NMI_VEC, saved=0);
//            else |active -> REQ (int_vec=VEC_BASE+idx, latch idx).
//   REQ:     int_req=1; int_vec frozen even if channel masks/drops or higher
//            priority arrives. inta -> SERVICE (clear edge bit idx).
//            nmi_pend before inta -> NMI_REQ, saved=0, channel stays pending.
//   SERVICE: in_service=1, new maskable requests wait. eoi -> IDLE.
//            nmi_pend -> NMI_REQ with saved=1 (ISR vector kept in a shadow reg).
//   NMI_REQ: nmi_req=1. inta -> NMI_SVC.
//   NMI_SVC: in_service=1. eoi -> SERVICE if saved (restore shadow vector) else IDLE.
//   Second NMI edge during NMI_REQ/NMI_SVC stays in nmi_pend, taken after return.
//  inta outside REQ/NMI_REQ and eoi outside SERVICE/NMI_SVC are ignored.
//  inta and nmi edge on same edge in REQ: inta wins, NMI taken from SERVICE.
//  Latency: edge irq sampled at edge k -> pending at k -> int_req high after k+1.
//   int_req/nmi_req drop the edge after inta. IDLE->REQ re-arb one cycle after eoi.
// TESTING
//  T1 mask=0, pulse irq[3] 1 cycle -> int_req at k+1, int_vec=8'h23; inta ->
//     int_req=0, in_service=1, pending[3]=0; eoi -> IDLE.
//  T2 irq[5] and irq[2] same cycle -> vec 8'h22 first; after eoi vec 8'h25.
//  T3 mask[4]=1, pulse irq[4] -> pending[4]=1, no int_req; clear mask -> int_req
//     two cycles after mask_we, vec 8'h24.
//  T4 in SERVICE of ch1, nmi edge -> nmi_req, vec 8'h02; inta, eoi -> back to
//     SERVICE with vec 8'h21, in_service=1; eoi -> IDLE.
//  T5 level ch0 (EDGE_MODE[0]=0) held high across inta/eoi -> re-requested after
//     eoi; deassert irq[0] -> no further int_req.
//  T6 rst_n low during REQ -> all outputs 0, mask=8'hFF asynchronously.

Source files
------------

// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller: NUM_IRQ maskable channels (edge or level
// per channel), one NMI line with a single level of nesting over a maskable ISR,
// and a vector output for the request currently presented or serviced.
module interrupt_controller #(
    parameter int unsigned          NUM_IRQ   = 8,
    parameter logic [NUM_IRQ-1:0]   EDGE_MODE = {NUM_IRQ{1'b1}},
    parameter int unsigned          VEC_W     = 8,
    parameter logic [VEC_W-1:0]     VEC_BASE  = VEC_W'(8'h20),
    parameter logic [VEC_W-1:0]     NMI_VEC   = VEC_W'(8'h02)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               nmi_i,
    input  logic               inta_i,
    input  logic               eoi_i,
    input  logic               mask_we_i,
    input  logic [NUM_IRQ-1:0] mask_wdata_i,
    output logic [NUM_IRQ-1:0] mask_o,
    output logic [NUM_IRQ-1:0] pending_o,
    output logic               int_req_o,
    output logic               nmi_req_o,
    output logic [VEC_W-1:0]   int_vec_o,
    output logic               in_service_o
);

    localparam int unsigned IdxW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StService,
        StNmiReq,
        StNmiSvc
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic               nmi_prev_q;
    logic               nmi_pend_q, nmi_pend_d;
    logic               saved_q, saved_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [VEC_W-1:0]   shadow_q, shadow_d;
    logic [IdxW-1:0]    idx_q, idx_d;

    logic [NUM_IRQ-1:0] active;
    logic               any_active;
    logic [IdxW-1:0]    win_idx;
    logic               chan_ack;
    logic               nmi_ack;

    assign active = pend_q & ~mask_q;

    // Lowest-numbered unmasked pending channel wins.
    always_comb begin
        any_active = 1'b0;
        win_idx    = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                any_active = 1'b1;
                win_idx    = IdxW'(i);
            end
        end
    end

    // FSM next state; the presented vector is frozen once a request is raised.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        idx_d    = idx_q;
        saved_d  = saved_q;
        shadow_d = shadow_q;
        chan_ack = 1'b0;
        nmi_ack  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (nmi_pend_q) begin
                    state_d = StNmiReq;
                    vec_d   = NMI_VEC;
                    saved_d = 1'b0;
                end else if (any_active) begin
                    state_d = StReq;
                    vec_d   = VEC_BASE + VEC_W'(win_idx);
                    idx_d   = win_idx;
                end
            end
            StReq: begin
                if (inta_i) begin
                    state_d  = StService;
                    chan_ack = 1'b1;
                end else if (nmi_pend_q) begin
                    // Unacknowledged channel stays pending and is re-arbitrated later.
                    state_d = StNmiReq;
                    vec_d   = NMI_VEC;
                    saved_d = 1'b0;
                end
            end
            StService: begin
                if (eoi_i) begin
                    state_d = StIdle;
                end else if (nmi_pend_q) begin
                    state_d  = StNmiReq;
                    shadow_d = vec_q;
                    vec_d    = NMI_VEC;
                    saved_d  = 1'b1;
                end
            end
            StNmiReq: begin
                if (inta_i) begin
                    state_d = StNmiSvc;
                    nmi_ack = 1'b1;
                end
            end
            StNmiSvc: begin
                if (eoi_i) begin
                    if (saved_q) begin
                        state_d = StService;
                        vec_d   = shadow_q;
                        saved_d = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pending bits: edge channels latch rising edges (set beats ack clear),
    // level channels simply follow the registered input.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (EDGE_MODE[i]) begin
                pend_d[i] = (irq_i[i] & ~irq_prev_q[i]) |
                            (pend_q[i] & ~(chan_ack && (idx_q == IdxW'(i))));
            end else begin
                pend_d[i] = irq_i[i];
            end
        end
        nmi_pend_d = (nmi_i & ~nmi_prev_q) | (nmi_pend_q & ~nmi_ack);
        mask_d     = mask_we_i ? mask_wdata_i : mask_q;
    end

    // State registers; reset drops any request or service in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            mask_q     <= '1;
            pend_q     <= '0;
            irq_prev_q <= '0;
            nmi_prev_q <= 1'b0;
            nmi_pend_q <= 1'b0;
            saved_q    <= 1'b0;
            vec_q      <= '0;
            shadow_q   <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            pend_q     <= pend_d;
            irq_prev_q <= irq_i;
            nmi_prev_q <= nmi_i;
            nmi_pend_q <= nmi_pend_d;
            saved_q    <= saved_d;
            vec_q      <= vec_d;
            shadow_q   <= shadow_d;
            idx_q      <= idx_d;
        end
    end

    assign mask_o       = mask_q;
    assign pending_o    = pend_q;
    assign int_req_o    = (state_q == StReq);
    assign nmi_req_o    = (state_q == StNmiReq);
    assign in_service_o = (state_q == StService) || (state_q == StNmiSvc);
    assign int_vec_o    = vec_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the controller.
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] irq;
    logic       nmi;
    logic       inta;
    logic       eoi;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic [7:0] mask;
    logic [7:0] pending;
    logic       int_req;
    logic       nmi_req;
    logic [7:0] int_vec;
    logic       in_service;

    int n_checks = 0;
    int n_fail   = 0;

    // Channel 0 is level-sensitive, all others edge-sensitive.
    interrupt_controller #(
        .NUM_IRQ  (8),
        .EDGE_MODE(8'hFE),
        .VEC_W    (8),
        .VEC_BASE (8'h20),
        .NMI_VEC  (8'h02)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_i       (irq),
        .nmi_i       (nmi),
        .inta_i      (inta),
        .eoi_i       (eoi),
        .mask_we_i   (mask_we),
        .mask_wdata_i(mask_wdata),
        .mask_o      (mask),
        .pending_o   (pending),
        .int_req_o   (int_req),
        .nmi_req_o   (nmi_req),
        .int_vec_o   (int_vec),
        .in_service_o(in_service)
    );

    always #5 clk = ~clk;

    // Behavioural model: what the core sees, as a phase of the handshake.
    localparam int P_IDLE = 0, P_WAIT_ACK = 1, P_ISR = 2, P_NMI_WAIT = 3, P_NMI_ISR = 4;
    int       m_phase;
    int       m_chan;
    bit [7:0] m_vec;
    bit [7:0] m_mask;
    bit [7:0] m_pend;
    bit [7:0] m_prev_irq;
    bit       m_prev_nmi;
    bit       m_nmi_pend;
    bit       m_nested;
    bit [7:0] m_isr_vec;

    task automatic model_reset();
        m_phase = P_IDLE; m_chan = 0; m_vec = 0; m_mask = 8'hFF; m_pend = 0;
        m_prev_irq = 0; m_prev_nmi = 0; m_nmi_pend = 0; m_nested = 0; m_isr_vec = 0;
    endtask

    task automatic model_step(input bit [7:0] i_irq, input bit i_nmi, input bit i_inta,
                              input bit i_eoi, input bit i_we, input bit [7:0] i_wd);
        int       lowest = -1;
        bit [7:0] np;
        bit       nnp;
        for (int c = 7; c >= 0; c--) begin
            if (m_pend[c] && !m_mask[c]) lowest = c;
        end
        for (int c = 0; c < 8; c++) begin
            if (c == 0) np[c] = i_irq[c];
            else np[c] = (i_irq[c] && !m_prev_irq[c]) ||
                         (m_pend[c] && !(m_phase == P_WAIT_ACK && i_inta && m_chan == c));
        end
        nnp = (i_nmi && !m_prev_nmi) || (m_nmi_pend && !(m_phase == P_NMI_WAIT && i_inta));
        case (m_phase)
            P_IDLE:
                if (m_nmi_pend) begin m_phase = P_NMI_WAIT; m_vec = 8'h02; m_nested = 0; end
                else if (lowest >= 0) begin
                    m_phase = P_WAIT_ACK; m_chan = lowest; m_vec = 8'(32 + lowest);
                end
            P_WAIT_ACK:
                if (i_inta) m_phase = P_ISR;
                else if (m_nmi_pend) begin m_phase = P_NMI_WAIT; m_vec = 8'h02; m_nested = 0; end
            P_ISR:
                if (i_eoi) m_phase = P_IDLE;
                else if (m_nmi_pend) begin
                    m_isr_vec = m_vec; m_vec = 8'h02; m_nested = 1; m_phase = P_NMI_WAIT;
                end
            P_NMI_WAIT:
                if (i_inta) m_phase = P_NMI_ISR;
            P_NMI_ISR:
                if (i_eoi) begin
                    if (m_nested) begin m_phase = P_ISR; m_vec = m_isr_vec; m_nested = 0; end
                    else m_phase = P_IDLE;
                end
            default: m_phase = P_IDLE;
        endcase
        m_pend     = np;
        m_nmi_pend = nnp;
        m_prev_irq = i_irq;
        m_prev_nmi = i_nmi;
        if (i_we) m_mask = i_wd;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("mask", 32'(mask), 32'(m_mask));
        check("pending", 32'(pending), 32'(m_pend));
        check("int_req", 32'(int_req), 32'(m_phase == P_WAIT_ACK));
        check("nmi_req", 32'(nmi_req), 32'(m_phase == P_NMI_WAIT));
        check("in_service", 32'(in_service), 32'(m_phase == P_ISR || m_phase == P_NMI_ISR));
        if (m_phase != P_IDLE) check("int_vec", 32'(int_vec), 32'(m_vec));
    endtask

    // One clock: inputs already stable, model advances at the edge, compare at negedge.
    task automatic tick();
        bit [7:0] c_irq = irq;
        bit       c_nmi = nmi;
        bit       c_inta = inta;
        bit       c_eoi = eoi;
        bit       c_we = mask_we;
        bit [7:0] c_wd = mask_wdata;
        @(posedge clk);
        model_step(c_irq, c_nmi, c_inta, c_eoi, c_we, c_wd);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        irq = 0; nmi = 0; inta = 0; eoi = 0; mask_we = 0; mask_wdata = 0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_mask", 32'(mask), 32'hFF);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_int_req", 32'(int_req), 32'h0);
        check("rst_nmi_req", 32'(nmi_req), 32'h0);
        check("rst_int_vec", 32'(int_vec), 32'h0);
        check("rst_in_service", 32'(in_service), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic unmask_all();
        mask_we = 1; mask_wdata = 8'h00; tick(); mask_we = 0;
        check("mask_cleared", 32'(mask), 32'h0);
    endtask

    initial begin
        do_reset();
        unmask_all();

        // T1: single edge request on channel 3
        irq = 8'h08; tick(); irq = 0;
        check("t1_pending3", 32'(pending[3]), 1);
        check("t1_no_req_yet", 32'(int_req), 0);
        tick();
        check("t1_int_req", 32'(int_req), 1);
        check("t1_vec", 32'(int_vec), 32'h23);
        inta = 1; tick(); inta = 0;
        check("t1_req_dropped", 32'(int_req), 0);
        check("t1_in_service", 32'(in_service), 1);
        check("t1_pending3_clr", 32'(pending[3]), 0);
        eoi = 1; tick(); eoi = 0;
        check("t1_idle", 32'(in_service), 0);

        // T2: simultaneous channels 5 and 2 -> lower index first
        irq = 8'h24; tick(); irq = 0; tick();
        check("t2_first_vec", 32'(int_vec), 32'h22);
        inta = 1; tick(); inta = 0;
        eoi = 1; tick(); eoi = 0;
        check("t2_pend5_waits", 32'(pending[5]), 1);
        tick();
        check("t2_second_req", 32'(int_req), 1);
        check("t2_second_vec", 32'(int_vec), 32'h25);
        inta = 1; tick(); inta = 0;
        eoi = 1; tick(); eoi = 0;

        // T3: masked channel 4 held pending until unmasked
        mask_we = 1; mask_wdata = 8'h10; tick(); mask_we = 0;
        irq = 8'h10; tick(); irq = 0; tick(); tick();
        check("t3_pending4", 32'(pending[4]), 1);
        check("t3_masked_no_req", 32'(int_req), 0);
        mask_we = 1; mask_wdata = 8'h00; tick(); mask_we = 0;
        check("t3_not_yet", 32'(int_req), 0);
        tick();
        check("t3_int_req", 32'(int_req), 1);
        check("t3_vec", 32'(int_vec), 32'h24);
        inta = 1; tick(); inta = 0;
        eoi = 1; tick(); eoi = 0;

        // T4: NMI nests over the channel 1 ISR
        irq = 8'h02; tick(); irq = 0; tick();
        inta = 1; tick(); inta = 0;
        nmi = 1; tick(); nmi = 0; tick();
        check("t4_nmi_req", 32'(nmi_req), 1);
        check("t4_nmi_vec", 32'(int_vec), 32'h02);
        inta = 1; tick(); inta = 0;
        check("t4_nmi_svc", 32'(in_service), 1);
        eoi = 1; tick(); eoi = 0;
        check("t4_restored_vec", 32'(int_vec), 32'h21);
        check("t4_restored_svc", 32'(in_service), 1);
        eoi = 1; tick(); eoi = 0;
        check("t4_idle", 32'(in_service), 0);

        // T5: level channel 0 re-requests while held
        irq = 8'h01; tick(); tick();
        check("t5_vec", 32'(int_vec), 32'h20);
        inta = 1; tick(); inta = 0;
        check("t5_level_kept", 32'(pending[0]), 1);
        eoi = 1; tick(); eoi = 0; tick();
        check("t5_rerequest", 32'(int_req), 1);
        irq = 0;
        inta = 1; tick(); inta = 0;
        eoi = 1; tick(); eoi = 0; tick(); tick();
        check("t5_no_more_req", 32'(int_req), 0);

        // T6: asynchronous reset while a request is outstanding
        irq = 8'h08; tick(); irq = 0; tick();
        check("t6_in_req", 32'(int_req), 1);
        #2;
        do_reset();
        unmask_all();

        // Random traffic, with one reset part-way through
        for (int cyc = 0; cyc < 3000; cyc++) begin
            irq        = 8'($urandom & $urandom & $urandom);
            nmi        = ($urandom_range(0, 15) == 0);
            inta       = ($urandom_range(0, 2) == 0);
            eoi        = ($urandom_range(0, 2) == 0);
            mask_we    = ($urandom_range(0, 31) == 0);
            mask_wdata = 8'($urandom & $urandom);
            tick();
            if (cyc == 1500) begin
                do_reset();
                unmask_all();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
